alu_req_scheduler: RTL and testbench
====================================

Name: alu_req_scheduler

Overview:
Shares one instance of the team's 32-bit combinational ALU between two requesters (e.g. datapath issue port 0 and a multi-cycle helper unit on port 1). It arbitrates round-robin, captures the winner's opcode and operands into registers, and drives the shared ALU from those registers. It registers the ALU output and returns it with a one-cycle done pulse tagged to the requester. Sits between the requesters and the ALU; the ALU is instantiated inside this block.

Parameters:
RESET_PRIO, 0, requester index (0 or 1) holding priority after reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 request, level.
op0  input  4  requester 0 ALU opcode.
a0  input  32  requester 0 operand A.
b0  input  32  requester 0 operand B.
req1  input  1  requester 1 request, level.
op1  input  4  requester 1 ALU opcode.
a1  input  32  requester 1 operand A.
b1  input  32  requester 1 operand B.
ack  output  2  one-hot; bit i pulses for one cycle when request i is captured.
done  output  2  one-hot; bit i pulses for one cycle when result i is valid.
result  output  32  registered ALU result; holds its value between done pulses.
err  output  1  high with done when the captured opcode was 13..15.
busy  output  1  high in EXEC and DONE.

Behaviour:
- Reset (asynchronous): state=IDLE, ack=0, done=0, result=0, err=0, busy=0, operand/op registers=0, priority pointer=RESET_PRIO. A reset during EXEC or DONE discards the operation and emits no done.
- Opcode map, executed by the ALU:
  - 0 NOT a, 1 NOT b, 2 AND, 3 OR, 4 XOR, 5 XNOR.
  - 6 SLT: 1 if a<b signed, else 0.
  - 7 SGT: 1 if a>b signed, else 0.
  - 8 LSL b by 1, 9 LSR b by 1, 10 ASR b by 1.
  - 11 ADD a+b, 12 SUB a-b, both mod 2^32, carry and overflow discarded.
  - 13..15: result 0 and err=1.
- FSM states:
  - IDLE: at a clock edge with any req high, grant one requester, latch its op/a/b, set ack[grant], go to EXEC. With no req, stay in IDLE.
  - EXEC: ack cleared. The ALU sees only the latched registers. At the edge, latch the ALU output into result, set err per opcode, set done[grant], go to DONE.
  - DONE: done high for exactly this cycle. At the edge, clear done and err, go to IDLE.
- Arbitration:
  - Requests are sampled only in IDLE. If both are high, the pointer's requester wins. If one is high, it wins regardless of the pointer.
  - After every grant the pointer moves to the other requester.
- Timing:
  - Request sampled at edge k: ack high in cycle k+1, done and result valid in cycle k+2.
  - The next sample is at edge k+3. Maximum throughput is 1 op per 3 cycles.
- Requester rules:
  - Hold req, op, a and b stable until ack is seen.
  - A req still high at the next IDLE edge is a new request.
  - Input changes after capture do not affect the result.
- result changes only at the EXEC→DONE edge.
- busy is combinational from state.

Test Plan:
- Reset, then req0 with op=11, a=5, b=3 -> ack=01 one cycle later, done=01 two cycles after the sample edge, result=8, err=0.
- req1 only with op=12, a=5, b=3 -> ack=10, done=10, result=2. Repeat with a=0, b=1 -> result=0xFFFF_FFFF.
- req0 and req1 held continuously from reset (RESET_PRIO=0): req0 op=10 b=0x8000_0000, req1 op=8 b=0x8000_0001 -> grants alternate 0,1,0,1, one done every 3 cycles; results 0xC000_0000 and 0x0000_0002.
- req0 with op=6, a=0xFFFF_FFFF, b=1 -> result=1. Same operands with op=7 -> result=0.
- req0 with op=14 -> done=01, err=1 for that one cycle, result=0. On the next op, err returns to 0.
- Assert reset in the cycle after ack (EXEC) -> no done pulse, result=0, state IDLE. The next req1 is serviced normally, with priority as after reset.

Source files
------------

// File: rtl/alu_req_scheduler.sv
// Two-port round-robin front end for a shared 32-bit combinational ALU.
// A grant captures the winner's opcode and operands, the ALU evaluates the
// captured values for one cycle, and the registered result comes back with
// a one-cycle done pulse tagged to the requester.

// Shared 32-bit combinational ALU. Opcodes 13..15 are undefined: they
// produce zero and raise bad_op.
module alu32 (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        bad_op
);

    // Opcode decode; every path assigns y and bad_op.
    always_comb begin
        y      = '0;
        bad_op = 1'b0;
        case (op)
            4'd0:    y = ~a;
            4'd1:    y = ~b;
            4'd2:    y = a & b;
            4'd3:    y = a | b;
            4'd4:    y = a ^ b;
            4'd5:    y = ~(a ^ b);
            4'd6:    y = {31'd0, ($signed(a) < $signed(b))};
            4'd7:    y = {31'd0, ($signed(a) > $signed(b))};
            4'd8:    y = {b[30:0], 1'b0};
            4'd9:    y = {1'b0, b[31:1]};
            4'd10:   y = {b[31], b[31:1]};
            4'd11:   y = a + b;
            4'd12:   y = a - b;
            default: begin
                y      = '0;
                bad_op = 1'b1;
            end
        endcase
    end

endmodule

module alu_req_scheduler #(
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [3:0]  op0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic [3:0]  op1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  ack,
    output logic [1:0]  done,
    output logic [31:0] result,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PRIO_INIT = (RESET_PRIO != 0);

    state_t      state_reg,  state_next;
    logic        grant_reg,  grant_next;
    logic        prio_reg,   prio_next;
    logic [3:0]  op_reg,     op_next;
    logic [31:0] a_reg,      a_next;
    logic [31:0] b_reg,      b_next;
    logic [1:0]  ack_reg,    ack_next;
    logic [1:0]  done_reg,   done_next;
    logic [31:0] result_reg, result_next;
    logic        err_reg,    err_next;

    logic        winner;
    logic [31:0] alu_y;
    logic        alu_bad;

    // The ALU only ever sees the captured registers, so requester inputs
    // may change freely once the request has been acknowledged.
    alu32 u_alu (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .y      (alu_y),
        .bad_op (alu_bad)
    );

    // Contention goes to the pointer; a lone request wins outright.
    assign winner = (req0 && req1) ? prio_reg : req1;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= 1'b0;
            prio_reg   <= PRIO_INIT;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            ack_reg    <= '0;
            done_reg   <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            prio_reg   <= prio_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            ack_reg    <= ack_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    // Next-state and capture logic; ack and done are single-cycle pulses.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        prio_next   = prio_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        ack_next    = '0;
        done_next   = '0;
        result_next = result_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    grant_next = winner;
                    prio_next  = ~winner;
                    op_next    = winner ? op1 : op0;
                    a_next     = winner ? a1  : a0;
                    b_next     = winner ? b1  : b0;
                    ack_next   = winner ? 2'b10 : 2'b01;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                result_next = alu_y;
                err_next    = alu_bad;
                done_next   = grant_reg ? 2'b10 : 2'b01;
                state_next  = DONE;
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ack    = ack_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign err    = err_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed cases followed by random traffic,
// checked against a behavioural ALU and arbitration model.
module tb_alu_req_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic [3:0]  op0 = '0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic        req1 = 1'b0;
    logic [3:0]  op1 = '0;
    logic [31:0] a1 = '0;
    logic [31:0] b1 = '0;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [31:0] result;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit ptr = 1'b0;               // model's priority pointer
    logic [31:0] last_result = '0;

    alu_req_scheduler #(.RESET_PRIO(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .ack    (ack),
        .done   (done),
        .result (result),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the opcode table, using plain arithmetic.
    function automatic logic [32:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        logic [31:0] y;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y = 32'd0;
        case (op)
            4'd0:  y = 32'hFFFF_FFFF - a;
            4'd1:  y = 32'hFFFF_FFFF - b;
            4'd2:  y = a & b;
            4'd3:  y = a | b;
            4'd4:  y = a ^ b;
            4'd5:  y = 32'hFFFF_FFFF - (a ^ b);
            4'd6:  y = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  y = (sa > sb) ? 32'd1 : 32'd0;
            4'd8:  y = 32'((64'(b) * 2) % 64'h1_0000_0000);
            4'd9:  y = b / 2;
            4'd10: y = (b / 2) + (b >= 32'h8000_0000 ? 32'h8000_0000 : 32'd0);
            4'd11: y = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd12: y = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            default: return {1'b1, 32'd0};
        endcase
        return {1'b0, y};
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        if (i == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else        begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr = 1'b0;
    endtask

    // Called at #1 after an edge with the DUT in IDLE and at least one req
    // driven. Runs the three-cycle transaction and checks every cycle.
    task automatic run_grant(input bit hold);
        bit g;
        logic [32:0] exp;
        logic [1:0] onehot;
        g = (req0 && req1) ? ptr : (req1 ? 1'b1 : 1'b0);
        exp = g ? model_alu(op1, a1, b1) : model_alu(op0, a0, b0);
        onehot = g ? 2'b10 : 2'b01;
        ptr = ~g;
        @(posedge clk); #1;
        check("ack", 32'(ack), 32'(onehot));
        check("done_at_ack", 32'(done), 32'd0);
        check("busy_exec", 32'(busy), 32'd1);
        check("result_hold_exec", result, last_result);
        if (!hold) begin
            if (g) begin req1 = 1'b0; op1 = 4'($urandom); a1 = $urandom; b1 = $urandom; end
            else   begin req0 = 1'b0; op0 = 4'($urandom); a0 = $urandom; b0 = $urandom; end
        end
        @(posedge clk); #1;
        check("ack_cleared", 32'(ack), 32'd0);
        check("done", 32'(done), 32'(onehot));
        check("result", result, exp[31:0]);
        check("err", 32'(err), 32'(exp[32]));
        check("busy_done", 32'(busy), 32'd1);
        last_result = exp[31:0];
        @(posedge clk); #1;
        check("done_cleared", 32'(done), 32'd0);
        check("err_cleared", 32'(err), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("result_hold", result, last_result);
        $display("txn grant=%0d result=%h err=%0d", g, exp[31:0], exp[32]);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        apply_reset();

        // Basic add on port 0, subtracts on port 1
        set_req(0, 4'd11, 32'd5, 32'd3);  run_grant(0);
        set_req(1, 4'd12, 32'd5, 32'd3);  run_grant(0);
        set_req(1, 4'd12, 32'd0, 32'd1);  run_grant(0);

        // Signed compares
        set_req(0, 4'd6, 32'hFFFF_FFFF, 32'd1); run_grant(0);
        set_req(0, 4'd7, 32'hFFFF_FFFF, 32'd1); run_grant(0);

        // Undefined opcode, then a normal one clears err
        set_req(0, 4'd14, 32'd9, 32'd9);  run_grant(0);
        set_req(0, 4'd3, 32'hF0, 32'h0F); run_grant(0);

        // Both held continuously from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        set_req(0, 4'd10, 32'd0, 32'h8000_0000);
        set_req(1, 4'd8, 32'd0, 32'h8000_0001);
        last_result = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr = 1'b0;
        for (int i = 0; i < 4; i++) run_grant(1);
        req0 = 1'b0; req1 = 1'b0;

        // Reset during EXEC: no done, priority restored
        set_req(0, 4'd11, 32'd7, 32'd9);
        @(posedge clk); #1;
        check("kill_ack", 32'(ack), 32'd1);
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        check("kill_done", 32'(done), 32'd0);
        check("kill_result", result, 32'd0);
        check("kill_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("kill_done_later", 32'(done), 32'd0);
        reset = 1'b0;
        ptr = 1'b0;
        last_result = 32'd0;
        set_req(0, 4'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        set_req(1, 4'd2, 32'hFFFF_0000, 32'h00FF_FF00);
        run_grant(0);   // pointer back at 0
        run_grant(0);   // req1 still pending

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            if (!req0 && $urandom_range(0, 2) != 0)
                set_req(0, 4'($urandom), rand_operand(), rand_operand());
            if (!req1 && $urandom_range(0, 2) != 0)
                set_req(1, 4'($urandom), rand_operand(), rand_operand());
            if (req0 || req1) begin
                run_grant(0);
            end else begin
                @(posedge clk); #1;
                check("idle_ack", 32'(ack), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
